// File: rtl/prog_rom_loader.sv
// Writable program memory for the TB4004 core: restores a default LED-chaser
// image after reset and accepts a byte-stream reload while the CPU is held.
module prog_rom_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  output logic              cpu_hold,
  input  logic              load_start,
  input  logic              load_end,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic [7:0]        ld_sum,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        sum_q, sum_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [7:0]        img_byte;
  logic [DATA_W-1:0] img_word;
  logic [7:0]        ld_byte;
  logic [31:0]       ptr_ext;
  logic              ptr_last;
  logic              xfer;

  // Default image: LED chaser pattern in the first six words, zeros elsewhere.
  assign ptr_ext = 32'(ptr_q);

  always_comb begin
    img_byte = 8'h00;
    case (ptr_ext)
      32'd0:   img_byte = 8'hB0;
      32'd1:   img_byte = 8'hB1;
      32'd2:   img_byte = 8'hB2;
      32'd3:   img_byte = 8'hB4;
      32'd4:   img_byte = 8'hB8;
      32'd5:   img_byte = 8'hF0;
      default: img_byte = 8'h00;
    endcase
  end

  generate
    if (DATA_W > 8) begin : g_img_wide
      assign img_word = {{(DATA_W-8){1'b0}}, img_byte};
      assign ld_byte  = ld_data[7:0];
    end else if (DATA_W == 8) begin : g_img_eq
      assign img_word = img_byte;
      assign ld_byte  = ld_data;
    end else begin : g_img_narrow
      assign img_word = img_byte[DATA_W-1:0];
      assign ld_byte  = {{(8-DATA_W){1'b0}}, ld_data};
    end
  endgenerate

  assign ptr_last = (ptr_q == {ADDR_W{1'b1}});

  // Handshake: a load byte transfers on a rising edge where ld_valid and
  // ld_ready are both high; ld_ready depends only on state, never on ld_valid.
  assign xfer = ld_valid && ld_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      out_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

  // The array has no reset; INIT rewrites every word instead.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    sum_d     = sum_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = img_word;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          sum_d   = '0;
        end
      end
      ST_LOAD: begin
        mem_wdata = ld_data;
        if (load_start) begin
          // Restart wins over a same-cycle byte and over load_end.
          ptr_d   = '0;
          count_d = '0;
          sum_d   = '0;
        end else begin
          if (xfer) begin
            mem_we  = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
            sum_d   = sum_q + ld_byte;
            if (ptr_last) begin
              state_d = ST_RUN;
            end
          end
          if (load_end) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    cpu_hold = (state_q != ST_RUN);
    ld_ready = (state_q == ST_LOAD);
    out_d    = '0;
    if (state_q == ST_RUN) begin
      out_d = mem[address];
    end
  end

  assign out       = out_q;
  assign ld_count  = count_q;
  assign ld_sum    = sum_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_rom_loader.sv
// Directed bench for prog_rom_loader: default image, reloads, overflow,
// restart and mid-load reset, each with hand-computed expectations.
module tb_prog_rom_loader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clock;
  logic              reset_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] out;
  logic              cpu_hold;
  logic              load_start;
  logic              load_end;
  logic [DATA_W-1:0] ld_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;
  logic [7:0]        ld_sum;
  logic [1:0]        dbg_state;

  int checks;
  int failures;

  prog_rom_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .address    (address),
    .out        (out),
    .cpu_hold   (cpu_hold),
    .load_start (load_start),
    .load_end   (load_end),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_count   (ld_count),
    .ld_sum     (ld_sum),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    address = a;
    tick();
    check($sformatf("fetch_%0h", a), 32'(out), 32'(exp));
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (cpu_hold && n < 40) begin
      tick();
      n++;
    end
    check(tag, n, 16);
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic v, input logic e);
    ld_data  = d;
    ld_valid = v;
    load_end = e;
    tick();
    ld_valid = 1'b0;
    load_end = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    logic [7:0] img [16];
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    address    = '0;
    load_start = 1'b0;
    load_end   = 1'b0;
    ld_data    = '0;
    ld_valid   = 1'b0;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'hB0; img[1] = 8'hB1; img[2] = 8'hB2;
    img[3] = 8'hB4; img[4] = 8'hB8; img[5] = 8'hF0;

    // reset state
    tick(); tick();
    check("rst_out", 32'(out), 0);
    check("rst_hold", 32'(cpu_hold), 1);
    check("rst_ready", 32'(ld_ready), 0);
    check("rst_count", 32'(ld_count), 0);
    check("rst_sum", 32'(ld_sum), 0);
    check("rst_state", 32'(dbg_state), 0);

    // default image
    reset_n = 1'b1;
    wait_run("init_cycles");
    for (int a = 0; a < 16; a++) fetch(ADDR_W'(a), img[a]);

    // plain load of three bytes
    start_load();
    check("ld_ready_on", 32'(ld_ready), 1);
    check("ld_hold_on", 32'(cpu_hold), 1);
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b1, 1'b0);
    send(8'h56, 1'b1, 1'b0);
    check("ld_out_zero", 32'(out), 0);
    send(8'h00, 1'b0, 1'b1);
    check("ld1_hold_off", 32'(cpu_hold), 0);
    check("ld1_first_out", 32'(out), 0);
    check("ld1_count", 32'(ld_count), 3);
    check("ld1_sum", 32'(ld_sum), 32'h9C);
    fetch(4'h0, 8'h12);
    fetch(4'h1, 8'h34);
    fetch(4'h2, 8'h56);
    fetch(4'h3, 8'hB4);

    // toggling valid, then a byte alongside load_end
    start_load();
    send(8'hA1, 1'b1, 1'b0);
    send(8'hEE, 1'b0, 1'b0);
    send(8'hA2, 1'b1, 1'b0);
    send(8'hEE, 1'b0, 1'b0);
    check("ld2_mid_count", 32'(ld_count), 2);
    send(8'hA3, 1'b1, 1'b1);
    check("ld2_count", 32'(ld_count), 3);
    check("ld2_sum", 32'(ld_sum), 32'hE6);
    check("ld2_hold_off", 32'(cpu_hold), 0);
    fetch(4'h0, 8'hA1);
    fetch(4'h1, 8'hA2);
    fetch(4'h2, 8'hA3);
    fetch(4'h3, 8'hB4);

    // 17 bytes offered; the 16th write ends the load
    start_load();
    for (int i = 1; i <= 16; i++) send(DATA_W'(i), 1'b1, 1'b0);
    check("ld3_ready_off", 32'(ld_ready), 0);
    check("ld3_hold_off", 32'(cpu_hold), 0);
    send(8'h11, 1'b1, 1'b0);
    check("ld3_count", 32'(ld_count), 16);
    check("ld3_sum", 32'(ld_sum), 32'h88);
    fetch(4'hF, 8'h10);
    fetch(4'h0, 8'h01);

    // restart mid-load discards the coincident byte
    start_load();
    send(8'h55, 1'b1, 1'b0);
    check("ld4_pre_count", 32'(ld_count), 1);
    load_start = 1'b1;
    send(8'h66, 1'b1, 1'b0);
    load_start = 1'b0;
    check("ld4_restart_count", 32'(ld_count), 0);
    check("ld4_restart_sum", 32'(ld_sum), 0);
    send(8'h77, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    check("ld4_count", 32'(ld_count), 1);
    check("ld4_sum", 32'(ld_sum), 32'h77);
    fetch(4'h0, 8'h77);
    fetch(4'h1, 8'h02);

    // reset during a load
    start_load();
    send(8'hAA, 1'b1, 1'b0);
    send(8'hBB, 1'b1, 1'b0);
    check("ld5_count", 32'(ld_count), 2);
    reset_n = 1'b0;
    #1;
    check("ld5_rst_count", 32'(ld_count), 0);
    check("ld5_rst_sum", 32'(ld_sum), 0);
    check("ld5_rst_hold", 32'(cpu_hold), 1);
    check("ld5_rst_state", 32'(dbg_state), 0);
    tick(); tick();
    reset_n = 1'b1;
    wait_run("reinit_cycles");
    fetch(4'h0, 8'hB0);
    fetch(4'h1, 8'hB1);
    fetch(4'hF, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
